// File: rtl/cordic_iter.sv
// Sequential CORDIC engine: one micro-rotation per clock on a shared datapath,
// rotation or vectoring mode, valid/ready handshakes on both sides.
module cordic_iter #(
  parameter int WIDTH = 24,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             busy
);

  localparam int KW  = $clog2(ITER + 1);
  localparam int TBL = 1 << KW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // atan(2^-idx) in Q2.(WIDTH-2), rounded; evaluated from a 2^60-scaled series
  function automatic logic [WIDTH-1:0] atan_entry(input int idx);
    logic [63:0] one;
    logic [63:0] acc;
    logic [63:0] term;
    int          sh;
    int          frac_sh;
    one  = 64'd1 << 60;
    acc  = 64'd0;
    term = 64'd0;
    if (idx == 0) begin
      acc = 64'h0C90_FDAA_2216_8C23;
    end else begin
      for (int n = 0; n < 32; n++) begin
        sh = idx * (2 * n + 1);
        if (sh < 61) begin
          term = (one >> sh) / 64'(2 * n + 1);
          if ((n % 2) == 0) begin
            acc = acc + term;
          end else begin
            acc = acc - term;
          end
        end else begin
          term = 64'd0;
        end
      end
    end
    frac_sh = 60 - (WIDTH - 2);
    acc     = acc + (64'd1 << (frac_sh - 1));
    return WIDTH'(acc >> frac_sh);
  endfunction

  logic [WIDTH-1:0] angle_s [TBL];

  for (genvar g = 0; g < TBL; g++) begin : g_tbl
    if (g < ITER) begin : g_ent
      assign angle_s[g] = atan_entry(g);
    end else begin : g_pad
      assign angle_s[g] = '0;
    end
  end

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic                    mode_q, mode_d;
  logic [KW-1:0]           k_q, k_d;

  logic signed [WIDTH-1:0] xs_s;
  logic signed [WIDTH-1:0] ys_s;
  logic                    dir_pos_s;

  // Shifted operands and rotation direction for the current iteration
  always_comb begin
    xs_s      = x_q >>> k_q;
    ys_s      = y_q >>> k_q;
    dir_pos_s = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          z_d     = in_z;
          mode_d  = in_mode;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (dir_pos_s) begin
          x_d = x_q - ys_s;
          y_d = y_q + xs_s;
          z_d = z_q - angle_s[k_q];
        end else begin
          x_d = x_q + ys_s;
          y_d = y_q - xs_s;
          z_d = z_q + angle_s[k_q];
        end
        k_d = k_q + KW'(1);
        if (k_q == KW'(ITER - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_z     = z_q;

endmodule
